// File: rtl/ymux_sched_if.sv
// Channel-side and output-side handshake bundle for the ymux_sched channel multiplexer.
// The master drives the channel and downstream inputs; the slave is the scheduler itself.
interface ymux_sched_if #(
   parameter int W  = 2,
   parameter int N  = 4,
   parameter int SW = $clog2(N)
);
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_chan;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/ymux_sched.sv
// N-to-1 channel scheduler with fixed-select or round-robin grant and a
// single registered output stage that supports full-throughput back-to-back transfers.
module ymux_sched #(
   parameter int W = 2,
   parameter int N = 4
) (
   input logic         clk,
   input logic         rst_n,
   ymux_sched_if.slave bus
);
   localparam int SW = $clog2(N);

   logic [SW-1:0] ptr_r;
   logic [SW-1:0] ptr_nxt_s;
   logic [W-1:0]  out_data_r;
   logic [SW-1:0] out_chan_r;
   logic          out_valid_r;
   logic          load_en_s;
   logic          grant_vld_s;
   logic [SW-1:0] grant_idx_s;
   logic [N-1:0]  in_ready_s;
   logic          xfer_s;

   // Grant selection: fixed index, or first valid channel at or after ptr with wrap-around.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
      if (bus.mode == 1'b0) begin
         for (int c = 0; c < N; c++) begin
            if (!grant_vld_s && (bus.sel == SW'(c)) && bus.in_valid[c]) begin
               grant_vld_s = 1'b1;
               grant_idx_s = SW'(c);
            end
         end
      end else begin
         // Upper segment (ptr..N-1) has priority over the wrapped segment (0..ptr-1).
         for (int c = 0; c < N; c++) begin
            if (!grant_vld_s && (SW'(c) >= ptr_r) && bus.in_valid[c]) begin
               grant_vld_s = 1'b1;
               grant_idx_s = SW'(c);
            end
         end
         for (int c = 0; c < N; c++) begin
            if (!grant_vld_s && (SW'(c) < ptr_r) && bus.in_valid[c]) begin
               grant_vld_s = 1'b1;
               grant_idx_s = SW'(c);
            end
         end
      end
   end

   // Load enable, one-hot ready, and the wrapped successor of the granted channel.
   always_comb begin
      load_en_s = !out_valid_r || bus.out_ready;
      xfer_s    = rst_n && load_en_s && grant_vld_s;
      in_ready_s = '0;
      for (int c = 0; c < N; c++) begin
         if (xfer_s && (grant_idx_s == SW'(c))) begin
            in_ready_s[c] = 1'b1;
         end else begin
            in_ready_s[c] = 1'b0;
         end
      end
      if (grant_idx_s == SW'(N - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = grant_idx_s + SW'(1);
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_chan_r  <= '0;
         ptr_r       <= '0;
      end else if (xfer_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= bus.in_data[grant_idx_s*W +: W];
         out_chan_r  <= grant_idx_s;
         if (bus.mode == 1'b1) begin
            ptr_r <= ptr_nxt_s;
         end else begin
            ptr_r <= ptr_r;
         end
      end else if (bus.out_ready) begin
         // Word consumed with nothing to replace it: data and channel keep their last values.
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_data  = out_data_r;
   assign bus.out_chan  = out_chan_r;
   assign bus.out_valid = out_valid_r;
endmodule

// File: doc/ymux_sched.md
YMUX_SCHED -- requirements
Module: ymux_sched

Interface
REQ-001 SHALL have parameter W, default 2, data width per channel in bits (W >= 1).
REQ-002 SHALL have parameter N, default 4, number of input channels (2 <= N <= 16).
REQ-003 SHALL have derived parameter SW = clog2(N), width of channel indices.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port in_data  input  N*W  channel c data at bits [c*W +: W].
REQ-007 SHALL have port in_valid  input  N  per-channel data-valid.
REQ-008 SHALL have port in_ready  output  N  per-channel accept; combinational.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SW  channel index used in fixed mode.
REQ-011 SHALL have port out_data  output  W  registered selected data.
REQ-012 SHALL have port out_chan  output  SW  registered index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  out_data/out_chan hold a word.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the word.

Function
REQ-015 SHALL define load_en = !out_valid || out_ready; the output register loads only when load_en is high and a grant exists.
REQ-016 SHALL transfer channel c when in_valid[c] && in_ready[c] at a rising edge; out_data = in_data[c], out_chan = c, out_valid = 1 from the next cycle (latency 1).
REQ-017 SHALL assert at most one in_ready bit in any cycle; in_ready[c] = load_en && (c == grant).
REQ-018 Fixed mode: grant = sel when sel < N and in_valid[sel] = 1; no grant otherwise, so the other channels see in_ready = 0.
REQ-019 Fixed mode, sel >= N: no grant, in_ready = 0, output register behaves as with no input.
REQ-020 Round-robin mode: grant = first c with in_valid[c] = 1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around); no grant if no in_valid bit is set.
REQ-021 Round-robin pointer ptr (SW bits) SHALL update to (granted c + 1) mod N on each round-robin transfer only; ptr SHALL hold when no transfer occurs or when mode = 0.
REQ-022 While out_valid && !out_ready, out_data, out_chan and out_valid SHALL hold stable and in_ready SHALL be all zero.
REQ-023 When out_valid && out_ready with no grant, out_valid SHALL drop to 0 next cycle; out_data and out_chan SHALL hold their last values.
REQ-024 When out_valid && out_ready with a grant, a new word SHALL load in the same edge (back-to-back, full throughput, no bubble).
REQ-025 A change of mode or sel SHALL affect only the grant computed in that cycle; no in-flight word is dropped or altered.
REQ-026 Arithmetic on ptr SHALL wrap modulo N, including non-power-of-two N.

Reset
REQ-027 On rst_n low, asynchronously: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0; in_ready SHALL be all zero while rst_n is low.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; after release, the first round-robin search starts at channel 0.

Verification (W=2, N=4)
REQ-029 Fixed: mode=0, sel=2, in_valid=4'b1111, in_data ch2=2'b10, out_ready=1 -> in_ready=4'b0100; next cycle out_data=2'b10, out_chan=2, out_valid=1.
REQ-030 Round-robin: mode=1, in_valid=4'b1011 held, out_ready=1 for 4 cycles -> out_chan sequence 0,1,3,0; ptr ends at 1.
REQ-031 Backpressure: word loaded, out_ready=0 for 3 cycles -> out_data/out_chan/out_valid stable, in_ready=4'b0000; out_ready=1 -> next word loads same edge.
REQ-032 Invalid select: mode=0, N=3 build, sel=3, in_valid=3'b111 -> in_ready=0 forever, out_valid stays 0.
REQ-033 Reset mid-operation: out_valid=1, ptr=2, rst_n pulsed low between edges -> out_valid, out_data, out_chan = 0 immediately; with in_valid=4'b1111 the first grant after release is channel 0.
REQ-034 Exhaustive data: all 4^4 in_data patterns x 4 sel values in fixed mode -> out_data equals in_data[sel*2 +: 2] one cycle later, checked with ===.
